// File: rtl/memory_access_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_access_stage
// MEM stage of a 5-stage RV32I pipeline. It latches the EX results, performs
// loads and stores over a request/response data-memory port, and hands the
// result plus commit information to write-back.
//
// Handshakes (both sides use the same valid/ready rule):
//   A transfer happens on a rising clk edge where the producer's valid and the
//   consumer's ready/allow are both high. Once valid is raised the producer
//   holds it and its payload stable until that transfer edge.
//   EX  -> MEM : e_to_m_valid / m_allow_in
//   MEM -> WB  : m_to_w_valid / w_allow_in
//   MEM -> dmem: dmem_req_valid / dmem_req_ready (exactly one request per op)
//   dmem -> MEM: dmem_rsp_valid (no ready; honoured only while waiting)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   e_to_m_valid, m_allow_in    EX-side handshake
//   m_valid                     MEM register holds an instruction
//   E_*                         decoded fields and pass-through data from EX
//   M_*                         registered copies of E_* toward WB
//   m_valM                      extended load data, 0 for non-loads
//   m_to_w_valid, w_allow_in    WB-side handshake
//   dmem_*                      data-memory request/response port
//   m_misalign                  misaligned-access flag
//   m_fsm_state                 current access FSM state (debug)
//
// Optional feature: define MEM_MISALIGN_CHK_EN to trap misaligned halfword and
// word accesses (no request issued, m_misalign raised with the result).
// Without it the low address bits below the access size are ignored.
// -----------------------------------------------------------------------------
module memory_access_stage #(
   parameter logic [6:0] LOAD_OP  = 7'b0000011,
   parameter logic [6:0] STORE_OP = 7'b0100011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        e_to_m_valid,
   output logic        m_allow_in,
   output logic        m_valid,
   input  logic [6:0]  E_opcode,
   input  logic [2:0]  E_funct3,
   input  logic [4:0]  E_rd,
   input  logic [31:0] E_valE,
   input  logic [31:0] E_valB,
   input  logic [31:0] E_default_pc,
   input  logic [31:0] E_cur_pc,
   input  logic [31:0] E_instr,
   input  logic [31:0] E_pred_pc,
   input  logic        E_commit,
   output logic [6:0]  M_opcode,
   output logic [4:0]  M_rd,
   output logic [31:0] M_valE,
   output logic [31:0] M_default_pc,
   output logic [31:0] M_cur_pc,
   output logic [31:0] M_instr,
   output logic [31:0] M_pred_pc,
   output logic        M_commit,
   output logic [31:0] m_valM,
   output logic        m_to_w_valid,
   input  logic        w_allow_in,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] dmem_addr,
   output logic        dmem_we,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        m_misalign,
   output logic [1:0]  m_fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        m_ready_go;
   logic [2:0]  funct3_q;
   logic [31:0] valb_q;
   logic [31:0] rdata_buf;
   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        misalign;
   logic [1:0]  lane;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign is_load  = (M_opcode == LOAD_OP);
   assign is_store = (M_opcode == STORE_OP);
   assign is_mem   = is_load | is_store;
   assign lane     = M_valE[1:0];

`ifdef MEM_MISALIGN_CHK_EN
   // funct3[1:0]: 00 byte, 01 halfword, 10 word (unsigned loads share the low bits)
   assign misalign = is_mem & (((funct3_q[1:0] == 2'b01) & M_valE[0]) |
                               ((funct3_q[1:0] == 2'b10) & (M_valE[1:0] != 2'b00)));
   assign m_misalign = m_to_w_valid & misalign;
`else
   assign misalign   = 1'b0;
   assign m_misalign = 1'b0;
`endif

   assign m_allow_in   = ~m_valid | (m_ready_go & w_allow_in);
   assign m_to_w_valid = m_valid & m_ready_go;
   assign m_fsm_state  = state;

   // Pipeline register. M_* only moves when the stage accepts a new valid
   // instruction, which also keeps the dmem request payload stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid      <= 1'b0;
         M_opcode     <= '0;
         M_rd         <= '0;
         M_valE       <= '0;
         M_default_pc <= '0;
         M_cur_pc     <= '0;
         M_instr      <= '0;
         M_pred_pc    <= '0;
         M_commit     <= 1'b0;
         funct3_q     <= '0;
         valb_q       <= '0;
      end else if (m_allow_in) begin
         m_valid <= e_to_m_valid;
         if (e_to_m_valid) begin
            M_opcode     <= E_opcode;
            M_rd         <= E_rd;
            M_valE       <= E_valE;
            M_default_pc <= E_default_pc;
            M_cur_pc     <= E_cur_pc;
            M_instr      <= E_instr;
            M_pred_pc    <= E_pred_pc;
            M_commit     <= E_commit;
            funct3_q     <= E_funct3;
            valb_q       <= E_valB;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Responses are only captured in WAIT; anything arriving in other states
   // (e.g. left over from before a reset) is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_buf <= '0;
      end else if ((state == WAIT) && dmem_rsp_valid) begin
         rdata_buf <= dmem_rdata;
      end
   end

   always_comb begin
      state_nxt      = state;
      m_ready_go     = 1'b0;
      dmem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            if (m_valid) begin
               if (!is_mem) begin
                  m_ready_go = 1'b1;
               end else if (misalign) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
               // stores are posted: no response is awaited
               state_nxt = is_store ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (dmem_rsp_valid) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            m_ready_go = 1'b1;
            if (w_allow_in) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dmem_addr = {M_valE[31:2], 2'b00};
   assign dmem_we   = is_store;

   always_comb begin
      dmem_wstrb = 4'b0000;
      dmem_wdata = valb_q;
      if (is_store) begin
         case (funct3_q[1:0])
            2'b00: begin
               dmem_wstrb = 4'b0001 << lane;
               dmem_wdata = {4{valb_q[7:0]}};
            end
            2'b01: begin
               dmem_wstrb = 4'b0011 << {lane[1], 1'b0};
               dmem_wdata = {2{valb_q[15:0]}};
            end
            default: begin
               dmem_wstrb = 4'b1111;
               dmem_wdata = valb_q;
            end
         endcase
      end
   end

   assign byte_sel = rdata_buf[{lane, 3'b000} +: 8];
   assign half_sel = rdata_buf[{lane[1], 4'b0000} +: 16];

   always_comb begin
      m_valM = '0;
      if (is_load && !misalign) begin
         case (funct3_q)
            3'b000:  m_valM = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  m_valM = {{16{half_sel[15]}}, half_sel};
            3'b010:  m_valM = rdata_buf;
            3'b100:  m_valM = {24'b0, byte_sel};
            3'b101:  m_valM = {16'b0, half_sel};
            default: m_valM = '0;
         endcase
      end
   end

endmodule
